// File: rtl/gnt_dist_pc_1to6.sv
// Grant distributor: steers an allocator port grant back to its owning VC slot
// and holds it there until that VC acknowledges it.
`ifndef NUM_PORT
`define NUM_PORT 5
`endif
`ifndef VC_INDEX_WIDTH
`define VC_INDEX_WIDTH 3
`endif

module gnt_dist_pc_1to6 #(
  parameter int NUM_PORT       = `NUM_PORT,
  parameter int NUM_VC         = 6,
  parameter int VC_INDEX_WIDTH = `VC_INDEX_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      gnt_valid,
  input  logic [VC_INDEX_WIDTH-1:0] sel,
  input  logic [NUM_PORT-1:0]       gnt_in,
  output logic                      gnt_ready,
  input  logic [NUM_VC-1:0]         vc_ack,
  output logic [NUM_PORT-1:0]       gnt_out_0,
  output logic [NUM_PORT-1:0]       gnt_out_1,
  output logic [NUM_PORT-1:0]       gnt_out_2,
  output logic [NUM_PORT-1:0]       gnt_out_3,
  output logic [NUM_PORT-1:0]       gnt_out_4,
  output logic [NUM_PORT-1:0]       gnt_out_5,
  output logic [NUM_VC-1:0]         gnt_hold,
  output logic [2:0]                pend_cnt,
  input  logic                      err_clr,
  output logic [1:0]                err
);

  logic [NUM_VC-1:0]   r_hold;
  logic [NUM_PORT-1:0] r_gnt [NUM_VC];
  logic [2:0]          r_pend;
  logic [1:0]          r_err;

  logic                w_sel_ok;
  logic                w_slot_free;
  logic                w_accept;
  logic                w_multi;
  logic                w_write;
  logic [1:0]          w_err_ev;
  logic [NUM_VC-1:0]   w_hold_nxt;
  logic [NUM_PORT-1:0] w_gnt_nxt [NUM_VC];
  logic [2:0]          w_pend_nxt;

  assign w_sel_ok = (32'(sel) < NUM_VC);

  // An out-of-range sel is always ready so the allocator can flush it and flag it.
  always_comb begin
    w_slot_free = 1'b1;
    for (int k = 0; k < NUM_VC; k++) begin
      if (32'(sel) == k) w_slot_free = ~r_hold[k] | vc_ack[k];
    end
  end

  assign gnt_ready = w_sel_ok ? w_slot_free : 1'b1;
  assign w_accept  = gnt_valid & gnt_ready;
  assign w_multi   = |(gnt_in & (gnt_in - NUM_PORT'(1)));
  assign w_write   = w_accept & w_sel_ok & ~w_multi & (|gnt_in);
  assign w_err_ev  = {w_accept & w_multi, w_accept & ~w_sel_ok};

  // Acks clear first; a write to the same slot then overrides the clear.
  always_comb begin
    w_pend_nxt = 3'd0;
    for (int k = 0; k < NUM_VC; k++) begin
      w_hold_nxt[k] = r_hold[k] & ~vc_ack[k];
      w_gnt_nxt[k]  = w_hold_nxt[k] ? r_gnt[k] : '0;
      if (w_write && (32'(sel) == k)) begin
        w_hold_nxt[k] = 1'b1;
        w_gnt_nxt[k]  = gnt_in;
      end
      w_pend_nxt = w_pend_nxt + 3'(w_hold_nxt[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold <= '0;
      r_pend <= 3'd0;
      r_err  <= 2'b00;
      for (int k = 0; k < NUM_VC; k++) r_gnt[k] <= '0;
    end else begin
      r_hold <= w_hold_nxt;
      r_pend <= w_pend_nxt;
      r_err  <= err_clr ? w_err_ev : (r_err | w_err_ev);
      for (int k = 0; k < NUM_VC; k++) r_gnt[k] <= w_gnt_nxt[k];
    end
  end

  assign gnt_hold  = r_hold;
  assign pend_cnt  = r_pend;
  assign err       = r_err;
  assign gnt_out_0 = r_gnt[0];
  assign gnt_out_1 = r_gnt[1];
  assign gnt_out_2 = r_gnt[2];
  assign gnt_out_3 = r_gnt[3];
  assign gnt_out_4 = r_gnt[4];
  assign gnt_out_5 = r_gnt[5];

endmodule

// File: tb/tb_gnt_dist_pc_1to6.sv
// Directed bench for gnt_dist_pc_1to6 with hand-computed expectations.
module tb_gnt_dist_pc_1to6;

  logic       clk = 1'b0;
  logic       reset;
  logic       gnt_valid;
  logic [2:0] sel;
  logic [4:0] gnt_in;
  logic       gnt_ready;
  logic [5:0] vc_ack;
  logic [4:0] go0, go1, go2, go3, go4, go5;
  logic [5:0] gnt_hold;
  logic [2:0] pend_cnt;
  logic       err_clr;
  logic [1:0] err;
  logic [29:0] outs;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gnt_dist_pc_1to6 dut (
    .clk(clk), .reset(reset), .gnt_valid(gnt_valid), .sel(sel), .gnt_in(gnt_in),
    .gnt_ready(gnt_ready), .vc_ack(vc_ack),
    .gnt_out_0(go0), .gnt_out_1(go1), .gnt_out_2(go2),
    .gnt_out_3(go3), .gnt_out_4(go4), .gnt_out_5(go5),
    .gnt_hold(gnt_hold), .pend_cnt(pend_cnt), .err_clr(err_clr), .err(err)
  );

  assign outs = {go5, go4, go3, go2, go1, go0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [4:0] g,
                       input logic [5:0] a, input logic c);
    gnt_valid = v; sel = s; gnt_in = g; vc_ack = a; err_clr = c;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 3'd0, 5'd0, 6'd0, 1'b0);
    tick();
    reset = 1'b0;
    chk("rst_hold", gnt_hold, 0);
    chk("rst_pend", pend_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_outs", outs, 0);
    chk("rst_ready", gnt_ready, 1);

    // first grant into slot 2
    drive(1'b1, 3'd2, 5'b00100, 6'd0, 1'b0);
    chk("t1_ready", gnt_ready, 1);
    tick();
    drive(1'b0, 3'd0, 5'd0, 6'd0, 1'b0);
    chk("t1_go2", go2, 5'b00100);
    chk("t1_hold", gnt_hold, 6'b000100);
    chk("t1_pend", pend_cnt, 1);
    chk("t1_outs", outs, 30'(5'b00100) << 10);

    // occupied slot backpressures, then ack+write reloads it
    drive(1'b1, 3'd2, 5'b00010, 6'd0, 1'b0);
    chk("t2_ready_busy", gnt_ready, 0);
    tick();
    chk("t2_keep", go2, 5'b00100);
    drive(1'b1, 3'd2, 5'b00010, 6'b000100, 1'b0);
    chk("t2_ready_ack", gnt_ready, 1);
    tick();
    drive(1'b0, 3'd0, 5'd0, 6'd0, 1'b0);
    chk("t2_go2", go2, 5'b00010);
    chk("t2_pend", pend_cnt, 1);
    chk("t2_hold", gnt_hold, 6'b000100);

    drive(1'b0, 3'd0, 5'd0, 6'b000100, 1'b0);
    tick();
    chk("t3_clr_pend", pend_cnt, 0);
    chk("t3_clr_go2", go2, 0);

    // fill all six slots back to back
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 3'(k), 5'(1 << (k % 5)), 6'd0, 1'b0);
      tick();
      chk($sformatf("t3_pend%0d", k), pend_cnt, 32'(k + 1));
    end
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 3'(k), 5'b00001, 6'd0, 1'b0);
      chk($sformatf("t3_full_ready%0d", k), gnt_ready, 0);
    end
    drive(1'b0, 3'd0, 5'd0, 6'd0, 1'b0);
    chk("t3_full_outs", outs, {5'b00001, 5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001});
    chk("t3_full_hold", gnt_hold, 6'b111111);
    drive(1'b0, 3'd0, 5'd0, 6'b111111, 1'b0);
    tick();
    chk("t3_ackall_hold", gnt_hold, 0);
    chk("t3_ackall_pend", pend_cnt, 0);
    chk("t3_ackall_outs", outs, 0);

    // error flags
    drive(1'b1, 3'd7, 5'b00001, 6'd0, 1'b0);
    chk("t4_ready_sel7", gnt_ready, 1);
    tick();
    chk("t4_sel7_hold", gnt_hold, 0);
    chk("t4_sel7_err", err, 2'b01);
    drive(1'b1, 3'd1, 5'b00011, 6'd0, 1'b0);
    tick();
    chk("t4_multi_hold", gnt_hold, 0);
    chk("t4_multi_err", err, 2'b11);
    drive(1'b0, 3'd0, 5'd0, 6'd0, 1'b1);
    tick();
    chk("t4_clr_err", err, 0);
    drive(1'b1, 3'd6, 5'b00100, 6'd0, 1'b1);
    tick();
    chk("t4_clr_vs_set", err, 2'b01);
    drive(1'b0, 3'd0, 5'd0, 6'd0, 1'b1);
    tick();
    chk("t4_clr2", err, 0);

    // zero grant, ack to empty slot, invalid cycle
    drive(1'b1, 3'd3, 5'd0, 6'd0, 1'b0);
    chk("t5_ready_zero", gnt_ready, 1);
    tick();
    chk("t5_zero_hold", gnt_hold, 0);
    chk("t5_zero_err", err, 0);
    drive(1'b0, 3'd0, 5'd0, 6'b010000, 1'b0);
    tick();
    chk("t5_ack_empty", gnt_hold, 0);
    chk("t5_ack_pend", pend_cnt, 0);
    drive(1'b0, 3'd0, 5'b00001, 6'd0, 1'b0);
    tick();
    chk("t5_novalid", gnt_hold, 0);

    // reset mid-operation
    drive(1'b1, 3'd1, 5'b00010, 6'd0, 1'b0);
    tick();
    drive(1'b1, 3'd4, 5'b01000, 6'd0, 1'b0);
    tick();
    drive(1'b1, 3'd7, 5'b00001, 6'd0, 1'b0);
    tick();
    chk("t6_pre_hold", gnt_hold, 6'b010010);
    chk("t6_pre_pend", pend_cnt, 2);
    chk("t6_pre_err", err, 2'b01);
    reset = 1'b1;
    drive(1'b1, 3'd0, 5'b00001, 6'd0, 1'b0);
    tick();
    reset = 1'b0;
    drive(1'b0, 3'd0, 5'd0, 6'd0, 1'b0);
    chk("t6_rst_hold", gnt_hold, 0);
    chk("t6_rst_outs", outs, 0);
    chk("t6_rst_pend", pend_cnt, 0);
    chk("t6_rst_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
